fetch_unit: RTL

Instruction-fetch stage of the single-issue MIPS-style core. Owns the program counter, drives the byte address into `instruction_memory`, and captures the returned word into the IF/ID pipeline register for decode. Handles stalls from the hazard unit, taken-branch redirects from execute, and local decode of `j`. Stops the core when the halt sentinel (opcode 6'h3F) reaches it non-speculatively.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_next_pc.sv | 36 +++
 rtl/fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, the halt sentinel word and the fetch FSM states shared by the core.
package cpu_pkg;
    localparam logic [5:0]  OP_J      = 6'h02;
    localparam logic [5:0]  OP_HALT   = 6'h3F;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC select for the fetch stage.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] START_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = OP_HALT
) (
    input  logic [31:0]  i_pc,
    input  fetch_state_t i_state,
    input  logic         i_start,
    input  logic         i_redirect,
    input  logic [31:0]  i_redirect_pc,
    input  logic         i_stall,
    input  logic [5:0]   i_opcode,
    input  logic [25:0]  i_jindex,
    output logic [31:0]  o_pc4,
    output logic [31:0]  o_next_pc
);
    logic [31:0] w_run_pc;
    assign o_pc4 = i_pc + 32'd4;
    // Stall holds the PC, but a redirect in the same cycle still wins.
    assign w_run_pc = i_redirect           ? i_redirect_pc :
                      i_stall              ? i_pc :
                      i_opcode == HALT_OP  ? i_pc :
                      i_opcode == OP_J     ? {o_pc4[31:28], i_jindex, 2'b00} :
                                             o_pc4;
    always_comb begin
        o_next_pc = i_pc;
        case (i_state)
            ST_BOOT:  o_next_pc = i_start ? START_PC : i_pc;
            ST_RUN:   o_next_pc = w_run_pc;
            ST_DRAIN: o_next_pc = i_redirect ? i_redirect_pc : i_pc;
            default:  o_next_pc = i_pc;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from instruction memory into IF/ID, and
// stops the core once a halt sentinel survives the redirect drain window.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'hFFFF_FFFC,
    parameter logic [31:0] START_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [5:0]  HALT_OP      = OP_HALT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic [5:0]  imem_control,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);
    fetch_state_t r_state, w_state_nxt;
    logic [31:0] r_pc, r_ifid_instr, r_ifid_pc4, r_fetch_count;
    logic [31:0] w_pc4, w_next_pc;
    logic [2:0]  r_drain, w_drain_nxt;
    logic        r_ifid_valid, w_valid_nxt, w_is_halt, w_load;

    fetch_next_pc #(.START_PC(START_PC), .HALT_OP(HALT_OP)) u_next_pc (
        .i_pc          (r_pc),
        .i_state       (r_state),
        .i_start       (start),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_stall       (stall),
        .i_opcode      (imem_control),
        .i_jindex      (imem_instr[25:0]),
        .o_pc4         (w_pc4),
        .o_next_pc     (w_next_pc)
    );

    assign w_is_halt = imem_control == HALT_OP;
    assign w_load    = r_state == ST_RUN && !redirect && !stall && !w_is_halt;

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_valid_nxt = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = start ? ST_RUN : ST_BOOT;
            ST_RUN: begin
                w_state_nxt = (!redirect && !stall && w_is_halt) ? ST_DRAIN : ST_RUN;
                w_drain_nxt = 3'(DRAIN_CYCLES - 1);
                w_valid_nxt = redirect ? 1'b0 : stall ? r_ifid_valid : w_load;
            end
            ST_DRAIN: begin
                w_state_nxt = redirect ? ST_RUN : (r_drain == 3'd0) ? ST_HALT : ST_DRAIN;
                w_drain_nxt = r_drain - 3'd1;
            end
            default: w_valid_nxt = r_ifid_valid;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_drain       <= 3'd0;
            r_ifid_instr  <= HALT_WORD;
            r_ifid_pc4    <= 32'd0;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_next_pc;
            r_drain      <= w_drain_nxt;
            r_ifid_valid <= w_valid_nxt;
            if (w_load) begin
                r_ifid_instr  <= imem_instr;
                r_ifid_pc4    <= w_pc4;
                r_fetch_count <= (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count : r_fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc4    = r_ifid_pc4;
    assign ifid_valid  = r_ifid_valid;
    assign halted      = r_state == ST_HALT;
    assign fetch_count = r_fetch_count;
endmodule
